// File: rtl/serial_magnitude_comparator_if.sv
// Request/result bundle for the serial magnitude comparator.
// The master issues operands and start; the slave reports busy/done and the g/e/l flags.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             g;
    logic             e;
    logic             l;

    modport master (
        output start,
        output signed_mode,
        output a,
        output b,
        input  busy,
        input  done,
        input  g,
        input  e,
        input  l
    );

    modport slave (
        input  start,
        input  signed_mode,
        input  a,
        input  b,
        output busy,
        output done,
        output g,
        output e,
        output l
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks DIGIT-bit slices MSB-first and stops at the
// first differing slice. Signed compares reuse the unsigned path via offset-binary mapping.
module serial_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    serial_magnitude_comparator_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

    typedef enum logic {
        IDLE,
        COMPARE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             g_reg;
    logic             e_reg;
    logic             l_reg;

    logic [WIDTH-1:0] sign_bit;
    logic [DIGIT-1:0] a_slices [N];
    logic [DIGIT-1:0] b_slices [N];
    logic [DIGIT-1:0] a_cur;
    logic [DIGIT-1:0] b_cur;
    logic             slice_gt;
    logic             slice_lt;

    always_comb begin
        sign_bit            = '0;
        sign_bit[WIDTH-1]   = 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign a_slices[gi] = a_reg[gi*DIGIT +: DIGIT];
            assign b_slices[gi] = b_reg[gi*DIGIT +: DIGIT];
        end

        if (N == 1) begin : g_single
            assign a_cur = a_slices[0];
            assign b_cur = b_slices[0];
        end else begin : g_multi
            assign a_cur = a_slices[idx_reg];
            assign b_cur = b_slices[idx_reg];
        end
    endgenerate

    assign slice_gt = (a_cur > b_cur);
    assign slice_lt = (a_cur < b_cur);

    // The sign bit is flipped at capture time; only the top slice sees the difference,
    // and the XOR of the two operands is unchanged so early termination is unaffected.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            g_reg     <= 1'b0;
            e_reg     <= 1'b0;
            l_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.signed_mode ? (bus.a ^ sign_bit) : bus.a;
                        b_reg     <= bus.signed_mode ? (bus.b ^ sign_bit) : bus.b;
                        idx_reg   <= IDX_TOP;
                        busy_reg  <= 1'b1;
                        state_reg <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (slice_gt || slice_lt) begin
                        g_reg     <= slice_gt;
                        l_reg     <= slice_lt;
                        e_reg     <= 1'b0;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (idx_reg == '0) begin
                        g_reg     <= 1'b0;
                        l_reg     <= 1'b0;
                        e_reg     <= 1'b1;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        idx_reg <= idx_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.g    = g_reg;
    assign bus.e    = e_reg;
    assign bus.l    = l_reg;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: directed scenarios plus randomized requests checked against an
// arithmetic reference (integer compare, latency from the highest differing bit).
module tb_serial_magnitude_comparator;
    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    localparam logic [2:0] GEL_G = 3'b100;
    localparam logic [2:0] GEL_E = 3'b010;
    localparam logic [2:0] GEL_L = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

    serial_magnitude_comparator #(
        .WIDTH(WIDTH),
        .DIGIT(DIGIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int ref_latency(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] diff;
        diff = x ^ y;
        if (diff == '0) return N;
        for (int p = WIDTH - 1; p >= 0; p--) begin
            if (diff[p]) return N - (p / DIGIT);
        end
        return N;
    endfunction

    function automatic logic [2:0] ref_gel(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic s);
        longint xv, yv;
        xv = s ? longint'($signed(x)) : longint'(x);
        yv = s ? longint'($signed(y)) : longint'(y);
        if (xv > yv) return GEL_G;
        if (xv < yv) return GEL_L;
        return GEL_E;
    endfunction

    function automatic logic [2:0] flags();
        return {bus.g, bus.e, bus.l};
    endfunction

    // Issue one request and measure it: cycles from accept to done, flags at done,
    // and whether busy stayed high until (and only until) done. lat = -1 on timeout.
    task automatic run_req(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                           output int lat, output logic [2:0] gel, output bit busy_ok);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.a           = x;
        bus.b           = y;
        bus.signed_mode = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom();
        bus.b     = $urandom();
        busy_ok   = (bus.busy === 1'b1) && (bus.done === 1'b0);
        lat       = -1;
        gel       = 3'bxxx;
        for (int c = 1; c <= N + 4; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat     = c;
                gel     = flags();
                busy_ok = busy_ok && (bus.busy === 1'b0);
                break;
            end
            busy_ok = busy_ok && (bus.busy === 1'b1);
        end
        $display("req a=%h b=%h signed=%0d latency=%0d gel=%b", x, y, s, lat, gel);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst             = 1'b1;
        bus.start       = 1'b1;
        bus.a           = 16'h1111;
        bus.b           = 16'h2222;
        bus.signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.g, bus.e, bus.l} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=00000", {bus.busy, bus.done, bus.g, bus.e, bus.l});
        end
        bus.start = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_capture busy=%b want=0", bus.busy);
        end
        $display("reset done busy=%b gel=%b", bus.busy, flags());
    endtask

    task automatic test_unsigned_late();
        int lat; logic [2:0] gel; bit bok;
        run_req(16'h1234, 16'h1235, 1'b0, lat, gel, bok);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL late_latency got=%0d want=4", lat); end
        checks++;
        if (gel !== GEL_L) begin errors++; $display("FAIL late_flags got=%b want=%b", gel, GEL_L); end
        checks++;
        if (!bok) begin errors++; $display("FAIL late_busy got=0 want=1"); end
    endtask

    task automatic test_sign();
        int lat; logic [2:0] gel; bit bok;
        run_req(16'h8000, 16'h7FFF, 1'b0, lat, gel, bok);
        checks++;
        if (lat !== 1 || gel !== GEL_G) begin
            errors++; $display("FAIL sign_unsigned got lat=%0d gel=%b want lat=1 gel=%b", lat, gel, GEL_G);
        end
        run_req(16'h8000, 16'h7FFF, 1'b1, lat, gel, bok);
        checks++;
        if (lat !== 1 || gel !== GEL_L) begin
            errors++; $display("FAIL sign_signed got lat=%0d gel=%b want lat=1 gel=%b", lat, gel, GEL_L);
        end
    endtask

    task automatic test_equality();
        int lat; logic [2:0] gel; bit bok; int bad;
        run_req(16'hBEEF, 16'hBEEF, 1'b0, lat, gel, bok);
        checks++;
        if (lat !== 4 || gel !== GEL_E) begin
            errors++; $display("FAIL equal got lat=%0d gel=%b want lat=4 gel=%b", lat, gel, GEL_E);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || flags() !== GEL_E) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL equal_hold bad_cycles=%0d want=0", bad); end
        $display("equality hold cycles=10 bad=%0d", bad);
    endtask

    task automatic test_ignore_busy();
        int lat; logic [2:0] gel;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h1235; bus.signed_mode = 1'b0;
        @(posedge clk);
        #1;
        bus.a = 16'hFFFF; bus.b = 16'h0000; bus.signed_mode = 1'b0;
        lat = -1;
        gel = 3'bxxx;
        for (int c = 1; c <= N + 4; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) bus.start = 1'b0;
            if (bus.done === 1'b1) begin lat = c; gel = flags(); break; end
        end
        bus.start = 1'b0;
        $display("req ignore_busy latency=%0d gel=%b", lat, gel);
        checks++;
        if (lat !== 4 || gel !== GEL_L) begin
            errors++; $display("FAIL ignore_busy got lat=%0d gel=%b want lat=4 gel=%b", lat, gel, GEL_L);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_idle busy=%b want=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [2:0] gel; bit bok;
        run_req(16'h4000, 16'h4001, 1'b0, lat, gel, bok);
        bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0000; bus.signed_mode = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b want=1", bus.busy); end
        lat = -1;
        for (int c = 1; c <= N + 4; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin lat = c; gel = flags(); break; end
        end
        $display("req back_to_back latency=%0d gel=%b", lat, gel);
        checks++;
        if (lat !== 4 || gel !== GEL_G) begin
            errors++; $display("FAIL b2b got lat=%0d gel=%b want lat=4 gel=%b", lat, gel, GEL_G);
        end
    endtask

    task automatic test_abort();
        int lat; logic [2:0] gel; bit bok; int seen;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'hFFF0; bus.b = 16'hFFF1; bus.signed_mode = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.g, bus.e, bus.l} !== 5'b0) begin
            errors++;
            $display("FAIL abort_outputs got=%b want=00000", {bus.busy, bus.done, bus.g, bus.e, bus.l});
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_no_done done_cycles=%0d want=0", seen); end
        run_req(16'h0003, 16'h0003, 1'b0, lat, gel, bok);
        checks++;
        if (lat !== 4 || gel !== GEL_E || !bok) begin
            errors++; $display("FAIL abort_restart got lat=%0d gel=%b busy_ok=%0d want lat=4 gel=%b busy_ok=1",
                               lat, gel, bok, GEL_E);
        end
    endtask

    task automatic test_random();
        int lat; logic [2:0] gel; bit bok;
        logic [WIDTH-1:0] x, y; logic s;
        for (int i = 0; i < 40; i++) begin
            x = WIDTH'($urandom());
            y = WIDTH'($urandom());
            s = 1'($urandom_range(0, 1));
            if (i % 5 == 0) y = x;
            else if (i % 3 == 0) y = x ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            run_req(x, y, s, lat, gel, bok);
            checks++;
            if (lat !== ref_latency(x, y) || gel !== ref_gel(x, y, s) || !bok) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h s=%0d got lat=%0d gel=%b busy_ok=%0d want lat=%0d gel=%b busy_ok=1",
                         i, x, y, s, lat, gel, bok, ref_latency(x, y), ref_gel(x, y, s));
            end
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        test_reset();
        test_unsigned_late();
        test_sign();
        test_equality();
        test_ignore_busy();
        test_back_to_back();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
